// File: rtl/fetch_stage_mips_if.sv
// Instruction-memory read port between the fetch stage and a
// variable-latency instruction memory (request/ready handshake).
interface fetch_stage_mips_if;
  logic        requestInstructionMemory;
  logic [31:0] addressInstructionMemory;
  logic        readyInstructionMemory;
  logic [31:0] dataInstructionMemory;

  modport master (
    output requestInstructionMemory,
    output addressInstructionMemory,
    input  readyInstructionMemory,
    input  dataInstructionMemory
  );

  modport slave (
    input  requestInstructionMemory,
    input  addressInstructionMemory,
    output readyInstructionMemory,
    output dataInstructionMemory
  );
endinterface

// File: rtl/fetch_stage_mips.sv
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program
// counter, fetches from a variable-latency instruction memory and loads the
// Fetch/Decode register. Redirects, stall and flush are applied here.
//
// state   | meaning
// --------+---------------------------------------------------------------
// REQUEST | request at programCounter outstanding; deliver word on ready
// DISCARD | redirected while a request was outstanding; drop its word,
//         | then continue at pendingTarget
// HOLD    | word arrived during a stall; parked in holdBuffer, no request
module fetch_stage_mips #(
  parameter logic [31:0] RESET_ADDRESS   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
  input  logic                      clock,
  input  logic                      resetMachine,
  fetch_stage_mips_if.master        imem,
  input  logic                      enableJumpProgramCounter_Decode,
  input  logic [31:0]               nextProgramCounterJump_Decode,
  input  logic                      enableBranchProgramCounter_Execute,
  input  logic [31:0]               nextProgramCounterBranch_Execute,
  input  logic                      stallFetch_HazardUnit,
  input  logic                      flushFetch_HazardUnit,
  output logic [31:0]               instruction_Fetch,
  output logic [31:0]               programCounterPlus4_Fetch
);

  typedef enum logic [1:0] {
    REQUEST = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetchState_t;

  fetchState_t state;
  logic [31:0] programCounter;
  logic [31:0] pendingTarget;
  logic [31:0] holdBuffer;

  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] programCounterPlus4;
  logic        deliver;
  logic [31:0] deliverWord;

  // Memory port: the request drops as soon as reset asserts so memory abandons it.
  always_comb begin
    imem.requestInstructionMemory = (state != HOLD) && !resetMachine;
    imem.addressInstructionMemory = programCounter;
  end

  // Redirect selection (Execute branch is older and wins) and delivery decode.
  always_comb begin
    redirect            = enableBranchProgramCounter_Execute | enableJumpProgramCounter_Decode;
    redirectTarget      = enableBranchProgramCounter_Execute ? nextProgramCounterBranch_Execute
                                                             : nextProgramCounterJump_Decode;
    programCounterPlus4 = programCounter + 32'd4;
    deliver             = 1'b0;
    deliverWord         = imem.dataInstructionMemory;
    case (state)
      REQUEST: begin
        if (imem.readyInstructionMemory && !redirect && !stallFetch_HazardUnit) begin
          deliver = 1'b1;
        end
      end
      HOLD: begin
        deliverWord = holdBuffer;
        if (!redirect && !stallFetch_HazardUnit) begin
          deliver = 1'b1;
        end
      end
      default: begin
        deliver = 1'b0;
      end
    endcase
  end

  // Fetch FSM, program counter and the Fetch/Decode pipeline register.
  always_ff @(posedge clock or posedge resetMachine) begin
    if (resetMachine) begin
      state                     <= REQUEST;
      programCounter            <= RESET_ADDRESS;
      pendingTarget             <= 32'd0;
      holdBuffer                <= 32'd0;
      instruction_Fetch         <= NOP_INSTRUCTION;
      programCounterPlus4_Fetch <= 32'd0;
    end else begin
      case (state)
        REQUEST: begin
          if (imem.readyInstructionMemory) begin
            if (redirect) begin
              programCounter <= redirectTarget;
            end else if (stallFetch_HazardUnit) begin
              holdBuffer <= imem.dataInstructionMemory;
              state      <= HOLD;
            end else begin
              programCounter <= programCounterPlus4;
            end
          end else if (redirect) begin
            pendingTarget <= redirectTarget;
            state         <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem.readyInstructionMemory) begin
            programCounter <= redirect ? redirectTarget : pendingTarget;
            state          <= REQUEST;
          end else if (redirect) begin
            pendingTarget <= redirectTarget;
          end
        end
        HOLD: begin
          if (redirect) begin
            programCounter <= redirectTarget;
            state          <= REQUEST;
          end else if (!stallFetch_HazardUnit) begin
            programCounter <= programCounterPlus4;
            state          <= REQUEST;
          end
        end
        default: begin
          state <= REQUEST;
        end
      endcase

      // Flush only clears the output register; fetch progress is unaffected.
      if (flushFetch_HazardUnit) begin
        instruction_Fetch         <= NOP_INSTRUCTION;
        programCounterPlus4_Fetch <= 32'd0;
      end else if (!stallFetch_HazardUnit) begin
        if (deliver) begin
          instruction_Fetch         <= deliverWord;
          programCounterPlus4_Fetch <= programCounterPlus4;
        end else begin
          instruction_Fetch         <= NOP_INSTRUCTION;
          programCounterPlus4_Fetch <= 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_mips.sv
// Directed bench for fetch_stage_mips. The memory model returns
// address + 0x1000_0000 as the instruction word whenever ready is high.
module tb_fetch_stage_mips;
  logic        clock = 1'b0;
  logic        resetMachine;
  logic        readyMem;
  logic        enableJump;
  logic [31:0] jumpTarget;
  logic        enableBranch;
  logic [31:0] branchTarget;
  logic        stall;
  logic        flush;
  logic [31:0] instruction_Fetch;
  logic [31:0] programCounterPlus4_Fetch;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_mips_if imem ();

  assign imem.readyInstructionMemory = readyMem;
  assign imem.dataInstructionMemory  = readyMem ? (imem.addressInstructionMemory + 32'h1000_0000)
                                                : 32'hDEAD_BEEF;

  fetch_stage_mips dut (
    .clock                              (clock),
    .resetMachine                       (resetMachine),
    .imem                               (imem),
    .enableJumpProgramCounter_Decode    (enableJump),
    .nextProgramCounterJump_Decode      (jumpTarget),
    .enableBranchProgramCounter_Execute (enableBranch),
    .nextProgramCounterBranch_Execute   (branchTarget),
    .stallFetch_HazardUnit              (stall),
    .flushFetch_HazardUnit              (flush),
    .instruction_Fetch                  (instruction_Fetch),
    .programCounterPlus4_Fetch          (programCounterPlus4_Fetch)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                           input logic req, input logic [31:0] addr);
    check({tag, ".instr"}, instruction_Fetch, instr);
    check({tag, ".pc4"}, programCounterPlus4_Fetch, pc4);
    check({tag, ".req"}, {31'd0, imem.requestInstructionMemory}, {31'd0, req});
    check({tag, ".addr"}, imem.addressInstructionMemory, addr);
  endtask

  initial begin
    resetMachine = 1'b1;
    readyMem     = 1'b1;
    enableJump   = 1'b0;
    jumpTarget   = 32'd0;
    enableBranch = 1'b0;
    branchTarget = 32'd0;
    stall        = 1'b0;
    flush        = 1'b0;
    #2;
    expectOut("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    resetMachine = 1'b0;
    #1;
    expectOut("release", 32'h0, 32'h0, 1'b1, 32'h0);

    // Zero-wait streaming
    step(); expectOut("seq0", 32'h1000_0000, 32'h4, 1'b1, 32'h4);
    step(); expectOut("seq4", 32'h1000_0004, 32'h8, 1'b1, 32'h8);

    // Two wait states at address 8
    readyMem = 1'b0;
    step(); expectOut("wait1", 32'h0, 32'h0, 1'b1, 32'h8);
    step(); expectOut("wait2", 32'h0, 32'h0, 1'b1, 32'h8);
    readyMem = 1'b1;
    step(); expectOut("seq8", 32'h1000_0008, 32'hC, 1'b1, 32'hC);
    step(); expectOut("seqC", 32'h1000_000C, 32'h10, 1'b1, 32'h10);

    // Jump while request at 0x10 is outstanding
    readyMem = 1'b0; enableJump = 1'b1; jumpTarget = 32'h40;
    step(); expectOut("discard", 32'h0, 32'h0, 1'b1, 32'h10);
    enableJump = 1'b0; readyMem = 1'b1;
    step(); expectOut("dropped", 32'h0, 32'h0, 1'b1, 32'h40);
    step(); expectOut("jump40", 32'h1000_0040, 32'h44, 1'b1, 32'h44);

    // Branch and jump together: branch wins
    enableBranch = 1'b1; branchTarget = 32'h100;
    enableJump   = 1'b1; jumpTarget   = 32'h200;
    step(); expectOut("brjmp", 32'h0, 32'h0, 1'b1, 32'h100);
    enableBranch = 1'b0; enableJump = 1'b0;
    step(); expectOut("br100", 32'h1000_0100, 32'h104, 1'b1, 32'h104);

    // Redirect overwrite while discarding
    readyMem = 1'b0; enableJump = 1'b1; jumpTarget = 32'h80;
    step(); expectOut("disc80", 32'h0, 32'h0, 1'b1, 32'h104);
    enableJump = 1'b0; enableBranch = 1'b1; branchTarget = 32'h90;
    step(); expectOut("disc90", 32'h0, 32'h0, 1'b1, 32'h104);
    enableBranch = 1'b0; readyMem = 1'b1;
    step(); expectOut("land90", 32'h0, 32'h0, 1'b1, 32'h90);
    step(); expectOut("seq90", 32'h1000_0090, 32'h94, 1'b1, 32'h94);

    // Stall when word at 0x20 arrives, flush during the stall
    enableJump = 1'b1; jumpTarget = 32'h1C;
    step(); expectOut("jmp1C", 32'h0, 32'h0, 1'b1, 32'h1C);
    enableJump = 1'b0;
    step(); expectOut("seq1C", 32'h1000_001C, 32'h20, 1'b1, 32'h20);
    stall = 1'b1;
    step(); expectOut("hold1", 32'h1000_001C, 32'h20, 1'b0, 32'h20);
    step(); expectOut("hold2", 32'h1000_001C, 32'h20, 1'b0, 32'h20);
    flush = 1'b1;
    step(); expectOut("flush", 32'h0, 32'h0, 1'b0, 32'h20);
    flush = 1'b0; stall = 1'b0;
    step(); expectOut("release20", 32'h1000_0020, 32'h24, 1'b1, 32'h24);

    // Wrap-around of PC+4
    enableJump = 1'b1; jumpTarget = 32'hFFFF_FFFC;
    step(); expectOut("jmpTop", 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    enableJump = 1'b0;
    step(); expectOut("wrap", 32'h0FFF_FFFC, 32'h0, 1'b1, 32'h0);
    step(); expectOut("after", 32'h1000_0000, 32'h4, 1'b1, 32'h4);

    // Reset in the middle of an outstanding request
    readyMem = 1'b0;
    step();
    #2;
    resetMachine = 1'b1;
    #1;
    expectOut("midreset", 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    resetMachine = 1'b0;
    readyMem     = 1'b1;
    step(); expectOut("restart", 32'h1000_0000, 32'h4, 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage_mips.md
# fetch_stage_mips

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, issues requests to a variable-latency instruction memory over a request/ready handshake, and loads the Fetch/Decode pipeline register feeding the decode stage. It accepts jump redirects from Decode and taken-branch redirects from Execute, plus stall and flush from the hazard unit, and inserts NOP bubbles while memory is not ready.

## Interface
- RESET_ADDRESS, 32'h0000_0000, program counter value after reset
- NOP_INSTRUCTION, 32'h0000_0000, instruction word used for bubbles/flushes
- clock  in  1  stage clock, all state updates on rising edge
- resetMachine  in  1  reset, asynchronous, active-high
- enableJumpProgramCounter_Decode  in  1  jump resolved in Decode this cycle
- nextProgramCounterJump_Decode  in  32  jump target
- enableBranchProgramCounter_Execute  in  1  taken branch resolved in Execute this cycle
- nextProgramCounterBranch_Execute  in  32  branch target
- stallFetch_HazardUnit  in  1  hold Fetch/Decode register
- flushFetch_HazardUnit  in  1  load NOP into Fetch/Decode register
- requestInstructionMemory  out  1  read request
- addressInstructionMemory  out  32  read address (word aligned)
- readyInstructionMemory  in  1  data valid / request accepted this cycle
- dataInstructionMemory  in  32  instruction word, valid when ready
- instruction_Fetch  out  32  registered instruction to Decode
- programCounterPlus4_Fetch  out  32  registered PC+4 of that instruction

## Operation
- Internal: programCounter (32), pendingTarget (32), holdBuffer (32), state in {REQUEST, DISCARD, HOLD}.
- Redirect = branch OR jump; target = branch target if enableBranch…_Execute, else jump target (Execute older, wins).
- requestInstructionMemory = 1 in REQUEST and DISCARD, 0 in HOLD; addressInstructionMemory = programCounter, stable while request high until ready.
- REQUEST, ready=1: redirect -> PC<=target, data dropped, stay REQUEST; else stall -> holdBuffer<=data, go HOLD; else deliver data, PC<=PC+4.
- REQUEST, ready=0: redirect -> pendingTarget<=target, go DISCARD; else stay.
- DISCARD, ready=1: PC<=pendingTarget, data dropped, go REQUEST. Redirect while in DISCARD overwrites pendingTarget; redirect in same cycle as ready -> PC<=new target.
- HOLD: redirect -> buffer dropped, PC<=target, go REQUEST; else stall released -> deliver holdBuffer, PC<=PC+4, go REQUEST.
- Fetch/Decode register priority each edge: flush -> {NOP_INSTRUCTION, 0}; else stall -> hold; else delivery -> {instruction, PC+4}; else bubble {NOP_INSTRUCTION, 0}.
- Flush affects only the output register; PC, state, holdBuffer untouched.
- PC+4 arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Targets used as given, no alignment check.

## Timing
- Reset (async): PC=RESET_ADDRESS, state=REQUEST, instruction_Fetch=NOP_INSTRUCTION, programCounterPlus4_Fetch=0, pendingTarget=0, holdBuffer=0; request forced 0 while resetMachine high, 1 from first cycle after release.
- Zero-wait memory (ready tied 1): one instruction per cycle; instruction at PC appears on instruction_Fetch one edge after the request cycle.
- Each ready=0 cycle without stall inserts one bubble.
- Redirect: target issued on request one cycle after redirect edge if ready that cycle, else after outstanding request completes (DISCARD).
- Reset mid-request: request dropped immediately; memory abandons it.

## Test plan
- Ready tied 1, reset release, PC=0 -> instructions from 0,4,8 on consecutive edges, programCounterPlus4_Fetch 4,8,12.
- Ready low 2 cycles at address 8 -> two bubbles (NOP, 0), address held at 8, then word at 8 with PC+4=12.
- Jump to 0x40 while request at 0x10 pending (ready=0) -> DISCARD; on ready word dropped, next request 0x40; no 0x10 word reaches Decode.
- Branch to 0x100 and jump to 0x200 same cycle -> next address 0x100.
- Stall when word at 0x20 arrives -> request low, outputs held; stall release -> 0x20 word with PC+4=0x24, request 0x24.
- PC=0xFFFF_FFFC fetched -> programCounterPlus4_Fetch=0, next address 0; flush during stall -> output NOP, PC unchanged.
